// File: rtl/priority_drain_encoder.sv
// Sequential priority encoder: accepts a request vector and emits the index of each set bit, one per handshake.
// Optional PENC_COUNT_EN adds cnt_o = number of indices still pending in the current vector.
//
// state | meaning
// IDLE  | no vector held; ready for a new one
// DRAIN | residual holds bits still to emit; idx_o valid
`timescale 1ns/1ps
module priority_drain_encoder #(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [WIDTH-1:0]           vec_i,
  input  logic                       vec_valid_i,
  output logic                       vec_ready_o,
  output logic [$clog2(WIDTH)-1:0]   idx_o,
  output logic                       idx_valid_o,
  input  logic                       idx_ready_i,
  output logic                       idx_last_o,
  output logic                       empty_o,
  input  logic                       flush_i
`ifdef PENC_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o
`endif
);

  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  residual_q, residual_d;
  logic              empty_q, empty_d;

  logic [IDXW-1:0]   prio_idx;
  logic [WIDTH-1:0]  prio_onehot;
  logic              single_bit;
  logic              in_drain;
  logic              emit;
  logic              accept;

  // Last assignment in the scan wins, so scan direction picks which end has priority.
  always_comb begin
    prio_idx    = '0;
    prio_onehot = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH-1; i >= 0; i--) begin
        if (residual_q[i]) begin
          prio_idx       = IDXW'(i);
          prio_onehot    = '0;
          prio_onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (residual_q[i]) begin
          prio_idx       = IDXW'(i);
          prio_onehot    = '0;
          prio_onehot[i] = 1'b1;
        end
      end
    end
  end

  assign single_bit  = (residual_q != '0) &&
                       ((residual_q & (residual_q - WIDTH'(1))) == '0);
  assign in_drain    = (state_q == DRAIN);

  assign idx_valid_o = in_drain;
  assign idx_o       = in_drain ? prio_idx : '0;
  assign idx_last_o  = in_drain && single_bit;
  assign empty_o     = empty_q;

  assign emit        = idx_valid_o && idx_ready_i;
  assign vec_ready_o = !in_drain || (emit && idx_last_o);
  assign accept      = vec_valid_i && vec_ready_o;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    empty_d    = 1'b0;
    if (flush_i) begin
      state_d    = IDLE;
      residual_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (vec_i != '0) begin
              state_d    = DRAIN;
              residual_d = vec_i;
            end else begin
              empty_d    = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (emit) begin
            if (!idx_last_o) begin
              residual_d = residual_q & ~prio_onehot;
            end else if (accept && (vec_i != '0)) begin
              residual_d = vec_i;
            end else begin
              state_d    = IDLE;
              residual_d = '0;
              empty_d    = accept;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          residual_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      residual_q <= '0;
      empty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      empty_q    <= empty_d;
    end
  end

`ifdef PENC_COUNT_EN
  localparam int CNTW = $clog2(WIDTH+1);

  logic [CNTW-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CNTW'(residual_q[i]);
    end
  end

  assign cnt_o = in_drain ? pop : '0;
`endif

endmodule

// File: tb/tb_priority_drain_encoder.sv
// Scoreboard bench for priority_drain_encoder: LSB-first and MSB-first instances share stimulus,
// each with its own expected-index queue checked by a monitor on the falling edge.
`timescale 1ns/1ps
module tb_priority_drain_encoder;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [W-1:0]  vec_i;
  logic          vec_valid_i;
  logic          idx_ready_i;
  logic          flush_i;

  logic          rdy_l, val_l, last_l, empty_l;
  logic          rdy_m, val_m, last_m, empty_m;
  logic [4:0]    idx_l, idx_m;
`ifdef PENC_COUNT_EN
  logic [5:0]    cnt_l, cnt_m;
`endif

  priority_drain_encoder #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk_i(clk_i), .rst_ni(rst_ni), .vec_i(vec_i), .vec_valid_i(vec_valid_i),
    .vec_ready_o(rdy_l), .idx_o(idx_l), .idx_valid_o(val_l), .idx_ready_i(idx_ready_i),
    .idx_last_o(last_l), .empty_o(empty_l), .flush_i(flush_i)
`ifdef PENC_COUNT_EN
    , .cnt_o(cnt_l)
`endif
  );

  priority_drain_encoder #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk_i(clk_i), .rst_ni(rst_ni), .vec_i(vec_i), .vec_valid_i(vec_valid_i),
    .vec_ready_o(rdy_m), .idx_o(idx_m), .idx_valid_o(val_m), .idx_ready_i(idx_ready_i),
    .idx_last_o(last_m), .empty_o(empty_m), .flush_i(flush_i)
`ifdef PENC_COUNT_EN
    , .cnt_o(cnt_m)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int idx;
    int last;
    int cnt;
  } exp_t;

  exp_t q_l[$];
  exp_t q_m[$];
  int   errors = 0;
  int   checks = 0;
  bit   exp_empty = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference order: walk the vector from the priority end and number the set bits.
  task automatic model_push(input logic [W-1:0] v);
    int n;
    int k;
    n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n++;
    k = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        q_l.push_back('{i, (k == n-1) ? 1 : 0, n-k});
        k++;
      end
    end
    k = 0;
    for (int i = W-1; i >= 0; i--) begin
      if (v[i]) begin
        q_m.push_back('{i, (k == n-1) ? 1 : 0, n-k});
        k++;
      end
    end
  endtask

  task automatic mon_one(input int sel, input logic val, input int idx, input int last, input int cnt);
    exp_t e;
    int   sz;
    sz = (sel == 0) ? q_l.size() : q_m.size();
    if (val) begin
      if (sz == 0) begin
        chk((sel == 0) ? "lsb_spurious_valid" : "msb_spurious_valid", 1, 0);
      end else begin
        e = (sel == 0) ? q_l[0] : q_m[0];
        chk((sel == 0) ? "lsb_idx" : "msb_idx", idx, e.idx);
        chk((sel == 0) ? "lsb_last" : "msb_last", last, e.last);
`ifdef PENC_COUNT_EN
        chk((sel == 0) ? "lsb_cnt" : "msb_cnt", cnt, e.cnt);
`endif
        if (idx_ready_i) begin
          if (sel == 0) void'(q_l.pop_front());
          else          void'(q_m.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      int c_l;
      int c_m;
`ifdef PENC_COUNT_EN
      c_l = int'(cnt_l);
      c_m = int'(cnt_m);
`else
      c_l = 0;
      c_m = 0;
`endif
      mon_one(0, val_l, int'(idx_l), int'(last_l), c_l);
      mon_one(1, val_m, int'(idx_m), int'(last_m), c_m);
      if (exp_empty || empty_l) chk("lsb_empty", int'(empty_l), int'(exp_empty));
      if (exp_empty || empty_m) chk("msb_empty", int'(empty_m), int'(exp_empty));
      exp_empty = 1'b0;
    end
  end

  // Holds vec_valid_i high until accepted; returns how many cycles it had to wait.
  task automatic send(input logic [W-1:0] v, output int waited);
    vec_i       = v;
    vec_valid_i = 1'b1;
    waited      = 0;
    @(negedge clk_i);
    while (!(rdy_l && !flush_i) && waited < 200) begin
      waited++;
      @(negedge clk_i);
    end
    if (waited >= 200) chk("accept_timeout", waited, 0);
    @(posedge clk_i);
    #1;
    if (v == '0) exp_empty = 1'b1;
    else         model_push(v);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_l.size() != 0 || q_m.size() != 0) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) chk("drain_timeout", n, 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int w;
    rst_ni      = 1'b0;
    vec_i       = '0;
    vec_valid_i = 1'b0;
    idx_ready_i = 1'b0;
    flush_i     = 1'b0;
    #12;
    chk("rst_ready", int'(rdy_l), 1);
    chk("rst_valid", int'(val_l), 0);
    chk("rst_last", int'(last_l), 0);
    chk("rst_idx", int'(idx_l), 0);
    chk("rst_empty", int'(empty_l), 0);
`ifdef PENC_COUNT_EN
    chk("rst_cnt", int'(cnt_l), 0);
`endif
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // basic three-bit vector in both orders
    idx_ready_i = 1'b1;
    send(32'h8000_0011, w);
    vec_valid_i = 1'b0;
    drain();
    chk("ready_after_vec", int'(rdy_l), 1);

    // all-zero vector
    send(32'h0, w);
    vec_valid_i = 1'b0;
    @(negedge clk_i);
    chk("zero_no_valid", int'(val_l), 0);
    chk("zero_ready", int'(rdy_l), 1);
    @(negedge clk_i);
    chk("zero_ready2", int'(rdy_l), 1);
    @(posedge clk_i);
    #1;

    // downstream stall
    idx_ready_i = 1'b0;
    send(32'h0000_0006, w);
    vec_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_valid", int'(val_l), 1);
      chk("stall_idx", int'(idx_l), 1);
    end
    @(posedge clk_i);
    #1;
    idx_ready_i = 1'b1;
    drain();

    // back-to-back vectors with valid held
    send(32'h1, w);
    send(32'h2, w);
    chk("no_bubble_wait", w, 0);
    vec_valid_i = 1'b0;
    drain();

    // flush mid-drain
    send(32'h0000_00F0, w);
    vec_valid_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    idx_ready_i = 1'b0;
    flush_i     = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    q_l.delete();
    q_m.delete();
    chk("flush_valid", int'(val_l), 0);
    chk("flush_ready", int'(rdy_l), 1);
`ifdef PENC_COUNT_EN
    chk("flush_cnt", int'(cnt_l), 0);
`endif
    idx_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;

    // reset pulse mid-vector
    send(32'h8000_0011, w);
    vec_valid_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    idx_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstpulse_valid", int'(val_l), 0);
    chk("rstpulse_ready", int'(rdy_l), 1);
`ifdef PENC_COUNT_EN
    chk("rstpulse_cnt", int'(cnt_l), 0);
`endif
    q_l.delete();
    q_m.delete();
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    idx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("post_reset_idle", int'(val_l), 0);
    end
    @(posedge clk_i);
    #1;

    // wider pattern including both ends
    send(32'hC000_A503, w);
    vec_valid_i = 1'b0;
    drain();

    chk("lsb_queue_empty", q_l.size(), 0);
    chk("msb_queue_empty", q_m.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
